// File: rtl/onehot_arbiter_rr.sv
// rtl/onehot_arbiter_rr.sv - registered one-hot round-robin/fixed arbiter with burst lock and advance handshake
module onehot_arbiter_rr #(
  parameter int W_REQ        = 4,
  parameter bit ROUND_ROBIN  = 1'b1,
  parameter bit HIGHEST_WINS = 1'b0,
  parameter int W_IDX        = (W_REQ > 1) ? $clog2(W_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_REQ-1:0] req,
  input  logic [W_REQ-1:0] lock,
  input  logic             advance,
  output logic [W_REQ-1:0] gnt,
  output logic             gnt_any,
  output logic [W_IDX-1:0] gnt_idx
);

  localparam int              W2      = 2 * W_REQ;
  localparam logic [W_IDX-1:0] LAST    = W_IDX'(W_REQ - 1);
  localparam logic [W_IDX-1:0] PTR_RST = HIGHEST_WINS ? LAST : '0;

  logic [W_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_any_q, gnt_any_d;
  logic [W_IDX-1:0] gnt_idx_q, gnt_idx_d;
  logic [W_IDX-1:0] ptr_q, ptr_d;
  logic [W_IDX-1:0] ptr_rel;
  logic [W_IDX-1:0] pick_ptr;
  logic [W_REQ-1:0] picked;

  // Ascending scan from p: upper copy of req catches the wrap, carry chain finds the first bit.
  function automatic logic [W_REQ-1:0] pick_asc(input logic [W_REQ-1:0] r,
                                                input logic [W_IDX-1:0] p);
    logic [W_REQ-1:0] mask;
    logic [W2-1:0]    dbl;
    logic [W2-1:0]    first;
    mask  = ~((W_REQ'(1) << p) - W_REQ'(1));
    dbl   = {r, r & mask};
    first = dbl & (~dbl + W2'(1));
    return first[W_REQ-1:0] | first[W2-1:W_REQ];
  endfunction

  function automatic logic [W_REQ-1:0] pick(input logic [W_REQ-1:0] r,
                                            input logic [W_IDX-1:0] p);
    logic [W_REQ-1:0] r_rev;
    logic [W_REQ-1:0] hit;
    logic [W_REQ-1:0] res;
    for (int i = 0; i < W_REQ; i++) r_rev[i] = r[W_REQ-1-i];
    if (HIGHEST_WINS) begin
      hit = pick_asc(r_rev, LAST - p);
      for (int i = 0; i < W_REQ; i++) res[i] = hit[W_REQ-1-i];
    end else begin
      res = pick_asc(r, p);
    end
    return res;
  endfunction

  always_comb begin
    ptr_rel = ptr_q;
    if (ROUND_ROBIN) begin
      if (HIGHEST_WINS) ptr_rel = (gnt_idx_q == '0) ? LAST : gnt_idx_q - W_IDX'(1);
      else              ptr_rel = (gnt_idx_q == LAST) ? '0 : gnt_idx_q + W_IDX'(1);
    end
    // On release the new grant is picked from the already-rotated pointer: no bubble.
    pick_ptr = gnt_any_q ? ptr_rel : ptr_q;
    picked   = pick(req, pick_ptr);
  end

  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (!gnt_any_q) begin
      gnt_d = picked;
    end else if (advance) begin
      if (!(lock[gnt_idx_q] && req[gnt_idx_q])) begin
        ptr_d = ptr_rel;
        gnt_d = picked;
      end
    end else if (!req[gnt_idx_q]) begin
      gnt_d = '0;
    end
    gnt_any_d = |gnt_d;
    gnt_idx_d = '0;
    for (int i = 0; i < W_REQ; i++) begin
      if (gnt_d[i]) gnt_idx_d = gnt_idx_d | W_IDX'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gnt_any_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      gnt_q     <= gnt_d;
      gnt_any_q <= gnt_any_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_any = gnt_any_q;
  assign gnt_idx = gnt_idx_q;

endmodule
